note_tone_gen: RTL and testbench

- Square-wave tone generator at the audio output end of the note path.
- The ULA computes note periods by dividing or taking the remainder against the semitone constant; software then hands each resulting period and a duration to this block.
- The block plays notes back-to-back without gaps, using a one-entry pending buffer, and reports completion of each note.

---
 rtl/note_tone_gen_if.sv | 33 +++
 rtl/note_tone_gen.sv | 128 ++++++++++++
 tb/tb_note_tone_gen.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_tone_gen_if.sv
`timescale 1ns/1ps
// Note handshake bundle between the note producer and note_tone_gen.
// Latency: none, wires only.
// Backpressure: producer holds NoteValid/NotePeriod/NoteDuration stable until NoteReady.
//
// Signals:
//   NoteValid    producer -> block   a note is offered
//   NoteReady    block -> producer   note can be accepted this cycle
//   NotePeriod   producer -> block   full tone period in cycles (0/1 = rest)
//   NoteDuration producer -> block   note length in cycles (0 = 1-cycle silent note)
interface note_tone_gen_if #(
    parameter int PERIOD_W = 32,
    parameter int DUR_W    = 24
);
    logic                NoteValid;
    logic                NoteReady;
    logic [PERIOD_W-1:0] NotePeriod;
    logic [DUR_W-1:0]    NoteDuration;

    modport master (
        output NoteValid,
        output NotePeriod,
        output NoteDuration,
        input  NoteReady
    );

    modport slave (
        input  NoteValid,
        input  NotePeriod,
        input  NoteDuration,
        output NoteReady
    );
endinterface

// File: rtl/note_tone_gen.sv
`timescale 1ns/1ps
// Square-wave tone generator playing (period, duration) notes back-to-back via a 1-entry pending buffer.
// Latency: an accepted note starts the cycle after the transfer (or right after the current note); NoteDone one cycle after its last cycle.
// Backpressure: NoteReady drops while a note is pending or Stop is high.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   note         slave side of note_tone_gen_if (NoteValid/NoteReady/NotePeriod/NoteDuration)
//   Stop         synchronous abort of the current and pending note
//   ToneOut      square-wave audio output
//   Busy         a note is playing or pending
//   NoteDone     one-cycle pulse after a note completes normally
module note_tone_gen #(
    parameter int PERIOD_W = 32,
    parameter int DUR_W    = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    note_tone_gen_if.slave note,
    input  logic           Stop,
    output logic           ToneOut,
    output logic           Busy,
    output logic           NoteDone
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] per;
    logic [PERIOD_W-1:0] phase_cnt;
    logic [DUR_W-1:0]    dur_cnt;
    logic                zero_dur;

    logic                pend_vld;
    logic [PERIOD_W-1:0] pend_per;
    logic [DUR_W-1:0]    pend_dur;

    logic                xfer;
    logic                last_cyc;
    logic                load_pend;
    logic                load_new;
    logic [PERIOD_W-1:0] src_per;
    logic [DUR_W-1:0]    src_dur;
    logic [PERIOD_W-1:0] phase_nxt;

    assign note.NoteReady = !pend_vld && !Stop;
    assign xfer           = note.NoteValid && note.NoteReady;

    // dur_cnt holds the cycles left including the current one, so 1 marks the last cycle.
    assign last_cyc = (state == PLAY) && (dur_cnt == DUR_W'(1));

    // The pending note always wins at the end of a note; a fresh note only loads
    // directly when nothing is queued ahead of it.
    always_comb begin
        load_pend = last_cyc && pend_vld;
        load_new  = xfer && ((state == IDLE) || (last_cyc && !pend_vld));
        src_per   = load_pend ? pend_per : note.NotePeriod;
        src_dur   = load_pend ? pend_dur : note.NoteDuration;
    end

    // Periods below 2 are rests: the phase counter is parked at 0.
    always_comb begin
        phase_nxt = '0;
        if (per >= PERIOD_W'(2) && phase_cnt != per - PERIOD_W'(1)) begin
            phase_nxt = phase_cnt + PERIOD_W'(1);
        end
    end

    // High for the first floor(Per/2) cycles of each period, so odd periods run longer low.
    assign ToneOut = (state == PLAY) && (per >= PERIOD_W'(2)) &&
                     (phase_cnt < (per >> 1)) && !zero_dur;
    assign Busy    = (state == PLAY) || pend_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            per       <= '0;
            phase_cnt <= '0;
            dur_cnt   <= '0;
            zero_dur  <= 1'b0;
            pend_vld  <= 1'b0;
            pend_per  <= '0;
            pend_dur  <= '0;
            NoteDone  <= 1'b0;
        end else if (Stop) begin
            // Abort drops both notes silently; a NoteDone already on the output has had its cycle.
            state     <= IDLE;
            per       <= '0;
            phase_cnt <= '0;
            dur_cnt   <= '0;
            zero_dur  <= 1'b0;
            pend_vld  <= 1'b0;
            NoteDone  <= 1'b0;
        end else begin
            NoteDone <= last_cyc;

            if (load_pend || load_new) begin
                state     <= PLAY;
                per       <= src_per;
                phase_cnt <= '0;
                dur_cnt   <= (src_dur == '0) ? DUR_W'(1) : src_dur;
                zero_dur  <= (src_dur == '0);
            end else if (last_cyc) begin
                state     <= IDLE;
                per       <= '0;
                phase_cnt <= '0;
                dur_cnt   <= '0;
                zero_dur  <= 1'b0;
            end else if (state == PLAY) begin
                // Not the last cycle, so dur_cnt >= 2 here and cannot underflow.
                dur_cnt   <= dur_cnt - DUR_W'(1);
                phase_cnt <= phase_nxt;
            end

            if (load_pend) begin
                pend_vld <= 1'b0;
            end else if (xfer && !load_new) begin
                pend_vld <= 1'b1;
                pend_per <= note.NotePeriod;
                pend_dur <= note.NoteDuration;
            end
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
`timescale 1ns/1ps
// Self-checking bench for note_tone_gen: a timeline model of accepted notes
// feeds a per-cycle monitor; directed pattern checks plus randomized traffic.
module tb_note_tone_gen;

    localparam int PW = 32;
    localparam int DW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic Stop  = 1'b0;
    logic ToneOut;
    logic Busy;
    logic NoteDone;

    note_tone_gen_if #(.PERIOD_W(PW), .DUR_W(DW)) nif ();

    note_tone_gen #(.PERIOD_W(PW), .DUR_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .note     (nif),
        .Stop     (Stop),
        .ToneOut  (ToneOut),
        .Busy     (Busy),
        .NoteDone (NoteDone)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One entry per accepted note: the cycles it occupies on the output.
    typedef struct {
        longint      start_c;
        longint      end_c;
        logic [31:0] per;
        logic        zero;
    } note_t;

    note_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pend_count(input longint k);
        int n = 0;
        foreach (q[i]) if (q[i].start_c > k) n++;
        return n;
    endfunction

    function automatic bit model_ready(input longint k);
        return !Stop && (pend_count(k) == 0);
    endfunction

    // A note starts the cycle after its transfer, or right after the last
    // queued note ends, whichever is later.
    task automatic model_accept(input longint k, input logic [31:0] p, input logic [23:0] d);
        note_t  n;
        longint s;
        s = k + 1;
        if (q.size() > 0 && q[$].end_c + 1 > s) s = q[$].end_c + 1;
        n.start_c = s;
        n.end_c   = s + ((d == 0) ? 1 : longint'(d)) - 1;
        n.per     = p;
        n.zero    = (d == 0);
        q.push_back(n);
    endtask

    // Monitor: every cycle, away from the edge.
    always @(negedge clk) begin : monitor
        longint k;
        longint pl;
        longint idx;
        bit     exp_done;
        bit     exp_tone;
        bit     exp_busy;
        if (mon_en && rst_n) begin
            k        = cyc;
            exp_done = (q.size() > 0) && (q[0].end_c == k - 1);
            check("NoteDone", 64'(NoteDone), 64'(exp_done));
            if (exp_done) void'(q.pop_front());
            exp_tone = 1'b0;
            exp_busy = 1'b0;
            foreach (q[i]) begin
                if (q[i].start_c <= k && k <= q[i].end_c) begin
                    pl       = longint'(q[i].per);
                    idx      = k - q[i].start_c;
                    exp_busy = 1'b1;
                    exp_tone = !q[i].zero && (pl >= 2) && ((idx % pl) < (pl / 2));
                end else if (q[i].start_c > k) begin
                    exp_busy = 1'b1;
                end
            end
            check("ToneOut",   64'(ToneOut),       64'(exp_tone));
            check("Busy",      64'(Busy),          64'(exp_busy));
            check("NoteReady", 64'(nif.NoteReady), 64'(model_ready(k)));
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic offer(input logic [31:0] p, input logic [23:0] d, input int stop_pct);
        bit done = 1'b0;
        nif.NoteValid    = 1'b1;
        nif.NotePeriod   = p;
        nif.NoteDuration = d;
        for (int w = 0; w < 400 && !done; w++) begin
            Stop = ($urandom_range(0, 99) < stop_pct);
            @(negedge clk); #2;
            if (Stop) q.delete();
            else if (model_ready(cyc)) begin
                model_accept(cyc, p, d);
                done = 1'b1;
            end
            @(posedge clk); #1;
            Stop = 1'b0;
        end
        nif.NoteValid    = 1'b0;
        nif.NotePeriod   = $urandom;
        nif.NoteDuration = 24'($urandom);
        if (!done) check("offer_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n, input int stop_pct);
        for (int i = 0; i < n; i++) begin
            Stop = ($urandom_range(0, 99) < stop_pct);
            @(negedge clk); #2;
            if (Stop) q.delete();
            @(posedge clk); #1;
            Stop = 1'b0;
        end
    endtask

    task automatic do_stop();
        Stop = 1'b1;
        @(negedge clk); #2;
        q.delete();
        @(posedge clk); #1;
        Stop = 1'b0;
    endtask

    task automatic capture(input int n, output logic [31:0] tones, output int dones);
        tones = '0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            tones = {tones[30:0], ToneOut};
            dones += int'(NoteDone);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] tones;
        int          dones;
        nif.NoteValid    = 1'b0;
        nif.NotePeriod   = '0;
        nif.NoteDuration = '0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_ToneOut",   64'(ToneOut),       64'(0));
        check("rst_Busy",      64'(Busy),          64'(0));
        check("rst_NoteDone",  64'(NoteDone),      64'(0));
        check("rst_NoteReady", 64'(nif.NoteReady), 64'(1));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Basic note
        offer(32'd4, 24'd8, 0);
        capture(8, tones, dones);
        check("basic_tone", 64'(tones[7:0]), 64'(8'b11001100));
        check("basic_no_early_done", 64'(dones), 64'(0));
        capture(1, tones, dones);
        check("basic_done", 64'(dones), 64'(1));

        // Gapless: second note queued while the first plays
        offer(32'd4, 24'd4, 0);
        offer(32'd6, 24'd6, 0);
        capture(9, tones, dones);
        check("gapless_tone", 64'(tones[8:0]), 64'(9'b100111000));
        check("gapless_first_done", 64'(dones), 64'(1));
        capture(1, tones, dones);
        check("gapless_second_done", 64'(dones), 64'(1));

        // Odd period then a rest
        offer(32'd5, 24'd10, 0);
        capture(10, tones, dones);
        check("odd_tone", 64'(tones[9:0]), 64'(10'b1100011000));
        offer(32'd0, 24'd3, 0);
        capture(3, tones, dones);
        check("rest_tone", 64'(tones[2:0]), 64'(0));
        capture(1, tones, dones);
        check("rest_done", 64'(dones), 64'(1));

        // Zero duration
        offer(32'd4, 24'd0, 0);
        capture(1, tones, dones);
        check("zero_tone", 64'(tones[0]), 64'(0));
        capture(1, tones, dones);
        check("zero_done", 64'(dones), 64'(1));

        // Stop on cycle 3 of a note, with a note pending
        offer(32'd4, 24'd8, 0);
        offer(32'd4, 24'd4, 0);
        idle(1, 0);
        do_stop();
        capture(12, tones, dones);
        check("stop_tone", 64'(tones[11:0]), 64'(0));
        check("stop_no_done", 64'(dones), 64'(0));

        // Asynchronous reset mid-note
        offer(32'd8, 24'd30, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ToneOut",   64'(ToneOut),       64'(0));
        check("arst_Busy",      64'(Busy),          64'(0));
        check("arst_NoteDone",  64'(NoteDone),      64'(0));
        check("arst_NoteReady", 64'(nif.NoteReady), 64'(1));
        q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        offer(32'd2, 24'd4, 0);
        capture(4, tones, dones);
        check("arst_after_tone", 64'(tones[3:0]), 64'(4'b1010));
        capture(1, tones, dones);
        check("arst_after_done", 64'(dones), 64'(1));

        // Randomized traffic with occasional Stop
        for (int n = 0; n < 150; n++) begin
            logic [31:0] p;
            logic [23:0] d;
            int          r;
            r = int'($urandom_range(0, 19));
            if (r < 12)      p = 32'(r % 8);
            else if (r < 18) p = 32'($urandom_range(8, 40));
            else             p = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            d = (r == 5) ? 24'd0 : 24'($urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)), 3);
            offer(p, d, 3);
        end

        idle(30, 0);
        check("drain_empty", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
